id_ex_pipe: RTL

- Decode→execute pipeline register with integrated hazard control. It sits directly downstream of the control unit and register file.
- It captures the decoded control bundle and operands each cycle, inserts bubbles on load-use hazards and taken-branch flushes, and emits forwarding selects for the execute-stage operand muxes.
- It converts the single-cycle control path into a 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_pkg.sv | 16 +
 rtl/id_ex_pipe_if.sv | 43 ++++
 rtl/id_ex_pipe_hazard_unit.sv | 37 +++
 rtl/id_ex_pipe.sv | 97 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control bundle, bubble constant and forwarding select encoding for the ID/EX stage.
package pipe_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       result_src;
    logic       jump;
    logic       jret;
    logic       branch;
    logic       bne;
    logic [3:0] alu_ctrl;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
endpackage

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: decode-side inputs, MEM/WB hazard inputs, execute-side outputs and hazard controls of the ID/EX register.
//   slave  : the pipeline register (consumes *_d, flush_e, hold_i, M/W info; drives *_e, stall_d, flush_d, fwd_*)
//   master : the surrounding datapath
//   ID_EX_PERF_EN adds bubble_cnt/flush_cnt.
interface id_ex_pipe_if #(parameter int DATA_W = 32, parameter int REG_W = 5) ();
  logic              valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d, jump_d, jret_d, branch_d, bne_d;
  logic [3:0]        alu_ctrl_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d;
  logic [REG_W-1:0]  rs1_d, rs2_d, rd_d;
  logic              flush_e, hold_i, reg_write_m, reg_write_w;
  logic [REG_W-1:0]  rd_m, rd_w;
  logic              valid_e, reg_write_e, alu_src_e, mem_write_e, result_src_e, jump_e, jret_e, branch_e, bne_e;
  logic [3:0]        alu_ctrl_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [REG_W-1:0]  rs1_e, rs2_e, rd_e;
  logic              stall_d, flush_d;
  logic [1:0]        fwd_a_e, fwd_b_e;
`ifdef ID_EX_PERF_EN
  logic [31:0]       bubble_cnt, flush_cnt;
`endif
  modport slave (
    input  valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d, jump_d, jret_d, branch_d, bne_d, alu_ctrl_d,
    input  rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
    input  flush_e, hold_i, reg_write_m, reg_write_w, rd_m, rd_w,
    output valid_e, reg_write_e, alu_src_e, mem_write_e, result_src_e, jump_e, jret_e, branch_e, bne_e, alu_ctrl_e,
    output rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    output stall_d, flush_d, fwd_a_e, fwd_b_e
`ifdef ID_EX_PERF_EN
    , output bubble_cnt, flush_cnt
`endif
  );
  modport master (
    output valid_d, reg_write_d, alu_src_d, mem_write_d, result_src_d, jump_d, jret_d, branch_d, bne_d, alu_ctrl_d,
    output rd1_d, rd2_d, imm_d, pc_d, pc_plus4_d, rs1_d, rs2_d, rd_d,
    output flush_e, hold_i, reg_write_m, reg_write_w, rd_m, rd_w,
    input  valid_e, reg_write_e, alu_src_e, mem_write_e, result_src_e, jump_e, jret_e, branch_e, bne_e, alu_ctrl_e,
    input  rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    input  stall_d, flush_d, fwd_a_e, fwd_b_e
`ifdef ID_EX_PERF_EN
    , input bubble_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/id_ex_pipe_hazard_unit.sv
// hazard_unit: combinational load-use detection, decode stall/flush and EX operand forwarding selects.
//   in : valid_d, rs1_d, rs2_d (decode); valid_e, result_src_e, rd_e, rs1_e, rs2_e (execute);
//        flush_e, hold_i; reg_write_m/rd_m, reg_write_w/rd_w
//   out: lu, stall_d, flush_d, fwd_a_e, fwd_b_e
module hazard_unit import pipe_pkg::*; #(
  parameter int REG_W = 5
) (
  input  logic             valid_d,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic             valid_e,
  input  logic             result_src_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic             flush_e,
  input  logic             hold_i,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_w,
  input  logic [REG_W-1:0] rd_w,
  output logic             lu,
  output logic             stall_d,
  output logic             flush_d,
  output fwd_sel_t         fwd_a_e,
  output fwd_sel_t         fwd_b_e
);
  logic m_ok, w_ok;
  assign m_ok = reg_write_m & (rd_m != '0);
  assign w_ok = reg_write_w & (rd_w != '0);
  assign lu = valid_d & valid_e & result_src_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
  // A taken branch discards the decode instruction, so there is nothing left to stall for.
  assign stall_d = hold_i | (lu & ~flush_e);
  assign flush_d = flush_e & ~hold_i;
  assign fwd_a_e = (m_ok && rd_m == rs1_e) ? FWD_MEM : (w_ok && rd_w == rs1_e) ? FWD_WB : FWD_RF;
  assign fwd_b_e = (m_ok && rd_m == rs2_e) ? FWD_MEM : (w_ok && rd_w == rs2_e) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode-to-execute pipeline register with load-use bubbles, flush bubbles and forwarding selects.
//   clk, rst : clock, synchronous active-high reset (clears every *_e, i.e. a bubble)
//   bus      : id_ex_pipe_if.slave (decode inputs, hazard inputs, execute outputs, stall_d/flush_d/fwd_*)
//   ID_EX_PERF_EN adds bubble_cnt/flush_cnt event counters.
module id_ex_pipe import pipe_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic          clk,
  input logic          rst,
  id_ex_pipe_if.slave  bus
);
  ctrl_t             ctrl_d, ctrl_e;
  logic              valid_e, lu, bubble;
  logic [DATA_W-1:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [REG_W-1:0]  rs1_e, rs2_e, rd_e;
  fwd_sel_t          fwd_a, fwd_b;
  logic              stall, flush;
  assign ctrl_d = {bus.reg_write_d, bus.alu_src_d, bus.mem_write_d, bus.result_src_d,
                   bus.jump_d, bus.jret_d, bus.branch_d, bus.bne_d, bus.alu_ctrl_d};
  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .valid_d      (bus.valid_d),
    .rs1_d        (bus.rs1_d),
    .rs2_d        (bus.rs2_d),
    .valid_e      (valid_e),
    .result_src_e (ctrl_e.result_src),
    .rd_e         (rd_e),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .flush_e      (bus.flush_e),
    .hold_i       (bus.hold_i),
    .reg_write_m  (bus.reg_write_m),
    .rd_m         (bus.rd_m),
    .reg_write_w  (bus.reg_write_w),
    .rd_w         (bus.rd_w),
    .lu           (lu),
    .stall_d      (stall),
    .flush_d      (flush),
    .fwd_a_e      (fwd_a),
    .fwd_b_e      (fwd_b)
  );
  assign bubble = bus.flush_e | lu;
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e     <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
    end else if (!bus.hold_i) begin
      ctrl_e     <= bubble ? CTRL_BUBBLE : ctrl_d;
      valid_e    <= ~bubble & bus.valid_d;
      rd1_e      <= bubble ? '0 : bus.rd1_d;
      rd2_e      <= bubble ? '0 : bus.rd2_d;
      imm_e      <= bubble ? '0 : bus.imm_d;
      pc_e       <= bubble ? '0 : bus.pc_d;
      pc_plus4_e <= bubble ? '0 : bus.pc_plus4_d;
      rs1_e      <= bubble ? '0 : bus.rs1_d;
      rs2_e      <= bubble ? '0 : bus.rs2_d;
      rd_e       <= bubble ? '0 : bus.rd_d;
    end
  end
  assign {bus.reg_write_e, bus.alu_src_e, bus.mem_write_e, bus.result_src_e,
          bus.jump_e, bus.jret_e, bus.branch_e, bus.bne_e, bus.alu_ctrl_e} = ctrl_e;
  assign bus.valid_e    = valid_e;
  assign bus.rd1_e      = rd1_e;
  assign bus.rd2_e      = rd2_e;
  assign bus.imm_e      = imm_e;
  assign bus.pc_e       = pc_e;
  assign bus.pc_plus4_e = pc_plus4_e;
  assign bus.rs1_e      = rs1_e;
  assign bus.rs2_e      = rs2_e;
  assign bus.rd_e       = rd_e;
  assign bus.stall_d    = stall;
  assign bus.flush_d    = flush;
  assign bus.fwd_a_e    = fwd_a;
  assign bus.fwd_b_e    = fwd_b;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      bubble_cnt <= bubble_cnt + {31'd0, lu & ~bus.flush_e & ~bus.hold_i};
      flush_cnt  <= flush_cnt + {31'd0, bus.flush_e & ~bus.hold_i};
    end
  end
  assign bus.bubble_cnt = bubble_cnt;
  assign bus.flush_cnt  = flush_cnt;
`endif
endmodule
